// File: rtl/priority_arbiter.sv
// priority_arbiter: registered N-port arbiter with fixed-priority or
// round-robin selection. Optionally it locks the grant until the request
// drops or the granted port acknowledges.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant outstanding, grant_valid=0, arbitrate every edge
// HELD  | grant outstanding, grant_valid=1, hold or re-arbitrate by mode

// priority_encoder: combinational highest-priority pick of a bit vector.
// It returns the winning index and the matching one-hot vector.
module priority_encoder #(
  parameter int WIDTH             = 4,
  parameter bit LSB_HIGH_PRIORITY = 1'b0
) (
  input  logic [WIDTH-1:0]         bits,
  output logic                     valid,
  output logic [$clog2(WIDTH)-1:0] encoded,
  output logic [WIDTH-1:0]         one_hot
);

  localparam int EW = $clog2(WIDTH);

  // Scan in the order that lets the highest-priority set bit be written last
  always_comb begin
    valid   = |bits;
    encoded = '0;
    one_hot = '0;
    if (LSB_HIGH_PRIORITY) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (bits[i]) encoded = EW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (bits[i]) encoded = EW'(i);
      end
    end
    if (valid) one_hot[encoded] = 1'b1;
  end

endmodule

module priority_arbiter #(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 0,
  parameter int ARB_BLOCK             = 0,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded
);

  localparam int  EW       = $clog2(PORTS);
  localparam bit  RR       = (ARB_TYPE_ROUND_ROBIN != 0);
  localparam bit  BLOCK    = (ARB_BLOCK != 0);
  localparam bit  BLOCK_AK = (ARB_BLOCK_ACK != 0);
  localparam bit  LSB_HIGH = (ARB_LSB_HIGH_PRIORITY != 0);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t           state;
  logic [PORTS-1:0] mask;
  logic [PORTS-1:0] request_masked;

  logic             masked_valid;
  logic [EW-1:0]    masked_encoded;
  logic [PORTS-1:0] masked_one_hot;
  logic             plain_valid;
  logic [EW-1:0]    plain_encoded;
  logic [PORTS-1:0] plain_one_hot;

  logic             pick_valid;
  logic [EW-1:0]    pick_encoded;
  logic [PORTS-1:0] pick_one_hot;
  logic [PORTS-1:0] next_mask;
  logic             rearbitrate;

  assign request_masked = request & mask;

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (LSB_HIGH)
  ) u_enc_masked (
    .bits    (request_masked),
    .valid   (masked_valid),
    .encoded (masked_encoded),
    .one_hot (masked_one_hot)
  );

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (LSB_HIGH)
  ) u_enc_plain (
    .bits    (request),
    .valid   (plain_valid),
    .encoded (plain_encoded),
    .one_hot (plain_one_hot)
  );

  // Winner: masked pick first in round robin, wrapping to the plain pick
  always_comb begin
    pick_valid   = plain_valid;
    pick_encoded = plain_encoded;
    pick_one_hot = plain_one_hot;
    if (RR && masked_valid) begin
      pick_encoded = masked_encoded;
      pick_one_hot = masked_one_hot;
    end
  end

  // Rotating mask: only ports after the winner in priority order stay eligible
  always_comb begin
    next_mask = '0;
    for (int j = 0; j < PORTS; j++) begin
      if (LSB_HIGH) next_mask[j] = (j > int'(pick_encoded));
      else          next_mask[j] = (j < int'(pick_encoded));
    end
  end

  // Decide whether this edge re-arbitrates or keeps the held grant
  always_comb begin
    rearbitrate = 1'b1;
    if (state == HELD && BLOCK) begin
      if (BLOCK_AK) rearbitrate = acknowledge[grant_encoded];
      else          rearbitrate = !request[grant_encoded];
    end
  end

  // Arbitration FSM; every output is a flop, and grant_encoded keeps its value in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '1;
    end else if (rearbitrate) begin
      if (pick_valid) begin
        state         <= HELD;
        grant         <= pick_one_hot;
        grant_valid   <= 1'b1;
        grant_encoded <= pick_encoded;
        if (RR) mask <= next_mask;
      end else begin
        state       <= IDLE;
        grant       <= '0;
        grant_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter. Six configurations share one stimulus stream.
// Directed steps push their expected outputs to a scoreboard. Random stress
// then checks the arbitration properties against a small independent model.
module tb_priority_arbiter;

  localparam int PORTS = 4;
  localparam int NDUT  = 6;
  // dut: 0 fixed/lsb  1 rr/lsb  2 rr/lsb/block-ack  3 fixed/lsb/block-drop
  //      4 fixed/msb  5 rr/msb
  localparam logic [NDUT-1:0] RR_CFG    = 6'b100110;
  localparam logic [NDUT-1:0] LSB_CFG   = 6'b001111;
  localparam logic [NDUT-1:0] BLOCK_CFG = 6'b001100;
  localparam logic [NDUT-1:0] ACK_CFG   = 6'b110111;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] request;
  logic [3:0] acknowledge;
  logic [3:0] grant_w [NDUT];
  logic       valid_w [NDUT];
  logic [1:0] enc_w   [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         dut;
    string      tag;
    logic [3:0] g;
    logic       v;
    logic [1:0] e;
  } exp_t;

  exp_t       sb [$];
  logic [1:0] last_enc [NDUT];
  logic [3:0] prev_g   [NDUT];
  int         wcnt     [NDUT][PORTS];

  always #5 clk = ~clk;

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    priority_arbiter #(
      .PORTS                 (PORTS),
      .ARB_TYPE_ROUND_ROBIN  (RR_CFG[i] ? 1 : 0),
      .ARB_BLOCK             (BLOCK_CFG[i] ? 1 : 0),
      .ARB_BLOCK_ACK         (ACK_CFG[i] ? 1 : 0),
      .ARB_LSB_HIGH_PRIORITY (LSB_CFG[i] ? 1 : 0)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .request       (request),
      .acknowledge   (acknowledge),
      .grant         (grant_w[i]),
      .grant_valid   (valid_w[i]),
      .grant_encoded (enc_w[i])
    );
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [3:0] top_bit(input logic [3:0] r);
    logic [3:0] t = 4'b0000;
    for (int i = 0; i < 4; i++) if (r[i]) t = 4'(1) << i;
    return t;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < NDUT; d++) begin
      last_enc[d] = 2'd0;
      prev_g[d]   = 4'b0000;
      for (int p = 0; p < PORTS; p++) wcnt[d][p] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    request = 4'b0000;
    acknowledge = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic pop_compare();
    exp_t x;
    if (sb.size() == 0) begin
      check_val("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      x = sb.pop_front();
      check_val({x.tag, ".grant"}, 32'(grant_w[x.dut]), 32'(x.g));
      check_val({x.tag, ".valid"}, 32'(valid_w[x.dut]), 32'(x.v));
      check_val({x.tag, ".enc"},   32'(enc_w[x.dut]),   32'(x.e));
    end
  endtask

  task automatic step(input int dut, input string tag, input logic [3:0] req,
                      input logic [3:0] ack, input logic [3:0] exp_g);
    exp_t x;
    @(negedge clk);
    request = req;
    acknowledge = ack;
    x.dut = dut;
    x.tag = tag;
    x.g   = exp_g;
    x.v   = |exp_g;
    if (|exp_g) last_enc[dut] = idx_of(exp_g);
    x.e = last_enc[dut];
    sb.push_back(x);
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    request = 4'b0000;
    acknowledge = 4'b0000;
    clear_model();
    #1;
    check_val("rst_grant", 32'(grant_w[2]), 32'd0);
    check_val("rst_valid", 32'(valid_w[2]), 32'd0);

    // async reset in the middle of a held grant, then mask reset
    do_reset();
    step(2, "t1_pre",  4'b0100, 4'b0000, 4'b0100);
    step(2, "t1_hold", 4'b0100, 4'b0000, 4'b0100);
    #3;
    rst = 1'b1;
    #1;
    check_val("t1_async.grant", 32'(grant_w[2]), 32'd0);
    check_val("t1_async.valid", 32'(valid_w[2]), 32'd0);
    check_val("t1_async.enc",   32'(enc_w[2]),   32'd0);
    @(posedge clk);
    #1;
    check_val("t1_inrst.grant", 32'(grant_w[2]), 32'd0);
    check_val("t1_inrst.valid", 32'(valid_w[2]), 32'd0);
    @(negedge clk);
    request = 4'b0000;
    rst = 1'b0;
    clear_model();
    step(2, "t1_mask", 4'b1111, 4'b0000, 4'b0001);

    // fixed priority, index 0 highest
    do_reset();
    step(0, "t2_a",    4'b1010, 4'b0000, 4'b0010);
    step(0, "t2_idle", 4'b0000, 4'b0000, 4'b0000);
    step(0, "t2_b",    4'b1100, 4'b0000, 4'b0100);
    step(0, "t2_c",    4'b1111, 4'b0000, 4'b0001);

    // fixed priority, index 3 highest
    do_reset();
    step(4, "msb_a",    4'b1010, 4'b0000, 4'b1000);
    step(4, "msb_b",    4'b0011, 4'b0000, 4'b0010);
    step(4, "msb_idle", 4'b0000, 4'b0000, 4'b0000);

    // round robin, index 0 first
    do_reset();
    step(1, "t3_r0", 4'b1111, 4'b0000, 4'b0001);
    step(1, "t3_r1", 4'b1111, 4'b0000, 4'b0010);
    step(1, "t3_r2", 4'b1111, 4'b0000, 4'b0100);
    step(1, "t3_r3", 4'b1111, 4'b0000, 4'b1000);
    step(1, "t3_r4", 4'b1111, 4'b0000, 4'b0001);
    step(1, "t3_sole0", 4'b0100, 4'b0000, 4'b0100);
    step(1, "t3_sole1", 4'b0100, 4'b0000, 4'b0100);
    step(1, "t3_alt0", 4'b0101, 4'b0000, 4'b0001);
    step(1, "t3_alt1", 4'b0101, 4'b0000, 4'b0100);
    step(1, "t3_alt2", 4'b0101, 4'b0000, 4'b0001);
    step(1, "t3_alt3", 4'b0101, 4'b0000, 4'b0100);

    // round robin, index 3 first
    do_reset();
    step(5, "rrm_0", 4'b1111, 4'b0000, 4'b1000);
    step(5, "rrm_1", 4'b1111, 4'b0000, 4'b0100);
    step(5, "rrm_2", 4'b1111, 4'b0000, 4'b0010);
    step(5, "rrm_3", 4'b1111, 4'b0000, 4'b0001);
    step(5, "rrm_4", 4'b1111, 4'b0000, 4'b1000);

    // round robin, locked until acknowledge
    do_reset();
    step(2, "t4_issue",   4'b0011, 4'b0000, 4'b0001);
    step(2, "t4_hold",    4'b0011, 4'b0000, 4'b0001);
    step(2, "t4_drop",    4'b0010, 4'b0000, 4'b0001);
    step(2, "t4_ack",     4'b0010, 4'b0001, 4'b0010);
    step(2, "t6_badack",  4'b0010, 4'b1000, 4'b0010);
    step(2, "t4_noreq",   4'b0000, 4'b0000, 4'b0010);
    step(2, "t4_release", 4'b0000, 4'b0010, 4'b0000);
    step(2, "t6_idleack", 4'b0000, 4'b1111, 4'b0000);
    step(2, "t4_wrap",    4'b0011, 4'b0000, 4'b0001);
    step(2, "t4_next",    4'b0011, 4'b0001, 4'b0010);
    step(2, "t4_again",   4'b0011, 4'b0010, 4'b0001);

    // fixed priority, locked until request drop
    do_reset();
    step(3, "t5_issue", 4'b0101, 4'b0000, 4'b0001);
    for (int k = 0; k < 5; k++) step(3, "t5_hold", 4'b0101, 4'b0000, 4'b0001);
    step(3, "t5_drop",  4'b0100, 4'b0000, 4'b0100);
    step(3, "t5_keep",  4'b0101, 4'b0000, 4'b0100);
    step(3, "t5_swap",  4'b0001, 4'b0000, 4'b0001);
    step(3, "t5_ackig", 4'b0001, 4'b0001, 4'b0001);
    step(3, "t5_idle",  4'b0000, 4'b0000, 4'b0000);

    // random stress
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      request = request ^ (4'($urandom) & 4'($urandom));
      acknowledge = 4'($urandom) & 4'($urandom);
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
        check_val("s_onehot", 32'($onehot0(grant_w[d])), 32'd1);
        check_val("s_valid",  32'(valid_w[d]), 32'(|grant_w[d]));
        if (grant_w[d] != prev_g[d] && grant_w[d] != 4'b0000)
          check_val("s_issue_req", 32'(|(grant_w[d] & request)), 32'd1);
        if (!BLOCK_CFG[d])
          check_val("s_busy", 32'(|grant_w[d]), 32'(|request));
      end
      check_val("s_fixed_lsb", 32'(grant_w[0]), 32'(request & (~request + 4'd1)));
      check_val("s_fixed_msb", 32'(grant_w[4]), 32'(top_bit(request)));
      if (prev_g[2] != 4'b0000 && !(|(acknowledge & prev_g[2])))
        check_val("s_ack_hold", 32'(grant_w[2]), 32'(prev_g[2]));
      if (prev_g[3] != 4'b0000 && (|(request & prev_g[3])))
        check_val("s_drop_hold", 32'(grant_w[3]), 32'(prev_g[3]));
      for (int d = 1; d < NDUT; d += 4) begin
        for (int p = 0; p < PORTS; p++) begin
          if (request[p]) begin
            if (grant_w[d][p]) wcnt[d][p] = 0;
            else begin
              wcnt[d][p]++;
              check_val("s_starve", 32'(wcnt[d][p] < PORTS), 32'd1);
            end
          end else begin
            wcnt[d][p] = 0;
          end
        end
      end
      for (int d = 0; d < NDUT; d++) prev_g[d] = grant_w[d];
    end

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
